// File: rtl/alu_accumulator.sv
// Accumulator ALU: single-cycle ops on ALU_reg_out, plus a W-step
// shift-add multiply that holds the accumulator until the product lands.
module alu_accumulator #(
    parameter int W = 4
) (
    input  logic             Clock,
    input  logic             Reset_b,
    input  logic             Start,
    input  logic [W-1:0]     Data,
    input  logic [2:0]       Function,
    output logic [2*W-1:0]   ALU_reg_out,
    output logic             Busy,
    output logic             Done
);

    localparam int OUT_W = 2 * W;
    localparam int CW    = (W > 2) ? $clog2(W) : 1;

    localparam logic [OUT_W-1:0] SHL_LIM  = OUT_W'(OUT_W);
    localparam logic [CW-1:0]    CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_HOLD = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [OUT_W-1:0]   r_acc;
    logic               r_done;
    logic [W-1:0]       r_a;
    logic [OUT_W-1:0]   r_b;
    logic [OUT_W-1:0]   r_pp;
    logic [CW-1:0]      r_cnt;

    state_t             w_state_nxt;
    logic [OUT_W-1:0]   w_acc_nxt;
    logic               w_done_nxt;
    logic [W-1:0]       w_a_nxt;
    logic [OUT_W-1:0]   w_b_nxt;
    logic [OUT_W-1:0]   w_pp_nxt;
    logic [CW-1:0]      w_cnt_nxt;

    logic [OUT_W-1:0]   w_a;
    logic [OUT_W-1:0]   w_b;
    logic [OUT_W-1:0]   w_shl;
    logic [OUT_W-1:0]   w_alu;
    logic [OUT_W-1:0]   w_step;

    assign w_a = {{W{1'b0}}, Data};
    assign w_b = {{W{1'b0}}, r_acc[W-1:0]};

    // Shift amounts at or beyond the result width flush to zero
    assign w_shl = (w_a >= SHL_LIM) ? '0 : (w_b << w_a);

    always_comb begin
        w_alu = r_acc;
        unique case (Function)
            OP_ADD:  w_alu = w_a + w_b;
            OP_MUL:  w_alu = r_acc;
            OP_SHL:  w_alu = w_shl;
            OP_HOLD: w_alu = r_acc;
            OP_SUB:  w_alu = w_a - w_b;
            OP_AND:  w_alu = w_a & w_b;
            OP_OR:   w_alu = w_a | w_b;
            OP_CLR:  w_alu = '0;
            default: w_alu = r_acc;
        endcase
    end

    assign w_step = r_a[r_cnt] ? (r_pp + (r_b << r_cnt)) : r_pp;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_done_nxt  = 1'b0;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_pp_nxt    = r_pp;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (Function == OP_MUL) begin
                        w_a_nxt     = Data;
                        w_b_nxt     = w_b;
                        w_pp_nxt    = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_MUL;
                    end else begin
                        w_acc_nxt  = w_alu;
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_MUL: begin
                w_pp_nxt  = w_step;
                w_cnt_nxt = r_cnt + CNT_ONE;
                if (r_cnt == CNT_LAST) begin
                    w_acc_nxt   = w_step;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset_b) begin
        if (Reset_b) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_pp    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_done  <= w_done_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_pp    <= w_pp_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign ALU_reg_out = r_acc;
    assign Busy        = (r_state == S_MUL);
    assign Done        = r_done;

endmodule

// File: doc/alu_accumulator.md
ALU_ACCUMULATOR -- requirements
Module: alu_accumulator

Interface
REQ-001 Parameter W, default 4, operand width in bits (legal range 2..16).
REQ-002 Parameter OUT_W, default 2*W, accumulator and result width; fixed at 2*W, not overridable.
REQ-003 Clock  input  1  sole clock; all state changes on the rising edge.
REQ-004 Reset_b  input  1  reset; asynchronous, active-high (Reset_b=1 resets regardless of Clock).
REQ-005 Start  input  1  operation request; sampled on a rising edge while idle.
REQ-006 Data  input  W  operand A, unsigned.
REQ-007 Function  input  3  opcode, sampled with Start.
REQ-008 ALU_reg_out  output  OUT_W  accumulator register, registered.
REQ-009 Busy  output  1  high while a multi-cycle multiply is in progress.
REQ-010 Done  output  1  registered one-cycle pulse marking result written.

Function
REQ-011 The operand is B = ALU_reg_out[W-1:0], zero-extended to OUT_W; A = Data, zero-extended to OUT_W.
REQ-012 Opcodes, unsigned, results truncated to OUT_W: 000 ADD A+B; 001 MUL A*B (multi-cycle); 010 SHL B<<A; 011 HOLD (accumulator unchanged); 100 SUB A-B modulo 2^OUT_W; 101 AND; 110 OR; 111 CLR (result 0).
REQ-013 SHL with A >= OUT_W yields 0.
REQ-014 The FSM has two states: IDLE and MUL.
REQ-015 In IDLE, if Start=1 on an edge with a non-MUL opcode, the result is written to ALU_reg_out on that edge and the FSM stays in IDLE.
REQ-016 After a write in IDLE, Done=1 for exactly the following cycle; this includes HOLD, which pulses Done.
REQ-017 In IDLE, if Start=1 with opcode 001, A and B are captured internally on that edge, a step counter is cleared, the FSM enters MUL and Busy=1 from the next cycle.
REQ-018 In MUL, each edge performs one shift-add step: if captured A bit[i]=1, add B<<i to an internal partial product.
REQ-019 The multiply takes exactly W steps; on the W-th step edge the final product is written to ALU_reg_out, the FSM returns to IDLE, and Busy falls.
REQ-020 Done=1 for the one cycle after the product is written, so Busy is high for exactly W cycles.
REQ-021 During MUL, ALU_reg_out holds its pre-multiply value.
REQ-022 During MUL, Start, Data and Function are ignored; no request is queued.
REQ-023 Start=1 in the cycle Done is high is accepted normally, allowing back-to-back operations with no dead cycle.
REQ-024 Start=0 in IDLE: no state change, Done=0.
REQ-025 The MUL product always fits OUT_W bits; no overflow occurs.
REQ-026 ADD, SUB and SHL results wrap or truncate silently; there is no flag output.

Reset
REQ-027 While Reset_b=1: ALU_reg_out=0, Busy=0, Done=0, FSM=IDLE, and the step counter and partial product are cleared; this takes effect immediately without waiting for a Clock edge.
REQ-028 Reset asserted mid-multiply aborts the operation: no Done pulse, and ALU_reg_out=0.
REQ-029 The first edge after Reset_b falls may accept Start.

Verification
REQ-030 W=4, reset, then ADD with Data=5 -> ALU_reg_out=0x05 after one edge; Done high one cycle; Busy stays 0.
REQ-031 Accumulator=0x05, MUL with Data=3 -> Busy high 4 cycles, ALU_reg_out stays 0x05 throughout, then 0x0F; Done pulses once.
REQ-032 Accumulator=0x0F: SHL Data=4 -> 0xF0; then SHL Data=9 -> 0x00 (B=0x0 also; repeat from 0x0F to confirm the A>=8 rule).
REQ-033 Accumulator=0x03, SUB Data=1 -> 0xFE; CLR -> 0x00; HOLD -> unchanged with Done pulse.
REQ-034 Start ADD during MUL -> ignored, MUL result unaffected; Start in the Done cycle -> accepted immediately.
REQ-035 Reset_b asserted between Clock edges in the 2nd MUL cycle -> outputs 0 immediately; no Done pulse; subsequent ADD Data=7 -> 0x07.
